// File: rtl/unshift_if.sv
// Stream interface for the unshift block: aligned input words in, lane-skewed
// output words out, each side with a valid/ready/last handshake.
interface unshift_if #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 32
) ();

  logic [WIDTH*DATA_WIDTH-1:0] unshift_din;
  logic                        unshift_din_vld;
  logic                        unshift_din_last;
  logic                        unshift_din_rdy;

  logic [WIDTH*DATA_WIDTH-1:0] unshift_dout;
  logic                        unshift_dout_vld;
  logic                        unshift_dout_last;
  logic                        unshift_dout_rdy;

  // Producer/consumer side (testbench or upstream/downstream logic)
  modport master (
    output unshift_din, unshift_din_vld, unshift_din_last, unshift_dout_rdy,
    input  unshift_din_rdy, unshift_dout, unshift_dout_vld, unshift_dout_last
  );

  // Block side
  modport slave (
    input  unshift_din, unshift_din_vld, unshift_din_last, unshift_dout_rdy,
    output unshift_din_rdy, unshift_dout, unshift_dout_vld, unshift_dout_last
  );

endinterface

// File: rtl/unshift.sv
// Lane-skew buffer: a tile of aligned words is written into one memory per
// lane, then read back with a per-lane address offset so each output word
// collects bytes from different input words (rectangle or diagonal pattern).
module unshift #(
  parameter int DATA_WIDTH = 8,
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  Rst,
  input  logic                  ByteRdIncr,
  input  logic [ADDR_WIDTH-1:0] ByteRdStep,
  input  logic [ADDR_WIDTH-1:0] RdBackStep,
  unshift_if.slave              io,
  output logic [ADDR_WIDTH:0]   fifo_count
);

  // Wide enough to hold rd_pointer + step*lane and step*group without loss
  localparam int LW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int FW = 2*ADDR_WIDTH + LW + 1;
  localparam logic [ADDR_WIDTH:0] LAST_ADDR = (ADDR_WIDTH+1)'(DEPTH - 1);

  typedef enum logic [0:0] {
    ST_IN  = 1'b0,
    ST_OUT = 1'b1
  } state_t;

  state_t                      state_r;
  state_t                      state_nxt_s;
  logic [ADDR_WIDTH:0]         wr_ptr_r;
  logic [ADDR_WIDTH:0]         rd_ptr_r;
  logic [ADDR_WIDTH:0]         n_r;
  logic [ADDR_WIDTH-1:0]       cnt_rd_grp_r;
  logic [ADDR_WIDTH:0]         fifo_count_r;
  logic [DATA_WIDTH-1:0]       mem_r [WIDTH][DEPTH];
  logic [WIDTH*DATA_WIDTH-1:0] dout_r;
  logic                        dout_vld_r;
  logic                        dout_last_r;

  logic [ADDR_WIDTH-1:0]       rd_addr_s [WIDTH];
  logic [ADDR_WIDTH-1:0]       back_eff_s;
  logic [FW-1:0]               wrap_s;
  logic                        din_hs_s;
  logic                        dout_hs_s;
  logic                        pop_s;
  logic                        to_out_s;
  logic                        to_in_s;
  logic                        grp_end_s;
  logic                        wr_en_s;

  // A group size of zero would make the modulo meaningless; use one instead
  assign back_eff_s = (RdBackStep == {ADDR_WIDTH{1'b0}}) ? ADDR_WIDTH'(1'b1) : RdBackStep;
  assign wrap_s     = FW'(ByteRdStep) * FW'(back_eff_s);

  // Write and read phases never overlap, so ready is just the phase decode
  assign io.unshift_din_rdy = (state_r == ST_IN);

  assign din_hs_s  = io.unshift_din_vld && (state_r == ST_IN);
  assign dout_hs_s = dout_vld_r && io.unshift_dout_rdy;
  assign pop_s     = (state_r == ST_OUT) && (rd_ptr_r < n_r) &&
                     (!dout_vld_r || io.unshift_dout_rdy);
  assign to_out_s  = din_hs_s && (io.unshift_din_last || (wr_ptr_r == LAST_ADDR));
  assign to_in_s   = (state_r == ST_OUT) && dout_hs_s && dout_last_r;
  assign grp_end_s = ((rd_ptr_r + (ADDR_WIDTH+1)'(1'b1)) % (ADDR_WIDTH+1)'(back_eff_s))
                     == {(ADDR_WIDTH+1){1'b0}};
  assign wr_en_s   = din_hs_s && !Rst;

  // Per-lane read address: wrapped rectangle or decrementing diagonal
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    logic [FW-1:0] off_s;
    logic [FW-1:0] sum_s;
    logic [FW-1:0] rect_s;

    assign off_s  = FW'(ByteRdStep) * FW'(g);
    assign sum_s  = FW'(rd_ptr_r) + off_s;
    assign rect_s = (sum_s >= wrap_s) ? (sum_s - wrap_s) : sum_s;
    assign rd_addr_s[g] = ByteRdIncr ? rect_s[ADDR_WIDTH-1:0] :
                          (rd_ptr_r[ADDR_WIDTH-1:0] - off_s[ADDR_WIDTH-1:0] + cnt_rd_grp_r);
  end

  // Next-state decode for the write/read phase machine
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IN: begin
        if (to_out_s) state_nxt_s = ST_OUT;
        else          state_nxt_s = ST_IN;
      end
      ST_OUT: begin
        if (to_in_s) state_nxt_s = ST_IN;
        else         state_nxt_s = ST_OUT;
      end
      default: state_nxt_s = ST_IN;
    endcase
  end

  // Phase register; the soft clear always returns to the write phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   state_r <= ST_IN;
    else if (Rst) state_r <= ST_IN;
    else          state_r <= state_nxt_s;
  end

  // Write/read pointers and latched tile length; cleared when a tile completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      n_r      <= {(ADDR_WIDTH+1){1'b0}};
    end else if (Rst || to_in_s) begin
      wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      n_r      <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      if (din_hs_s) wr_ptr_r <= wr_ptr_r + (ADDR_WIDTH+1)'(1'b1);
      if (to_out_s) n_r      <= wr_ptr_r + (ADDR_WIDTH+1)'(1'b1);
      if (pop_s)    rd_ptr_r <= rd_ptr_r + (ADDR_WIDTH+1)'(1'b1);
    end
  end

  // Channel-group counter that shifts the diagonal after every group of pops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt_rd_grp_r <= {ADDR_WIDTH{1'b0}};
    else if (Rst || to_in_s)     cnt_rd_grp_r <= {ADDR_WIDTH{1'b0}};
    else if (pop_s && grp_end_s) cnt_rd_grp_r <= cnt_rd_grp_r + ADDR_WIDTH'(1'b1);
  end

  // Occupancy: writes and pops never happen in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   fifo_count_r <= {(ADDR_WIDTH+1){1'b0}};
    else if (Rst) fifo_count_r <= {(ADDR_WIDTH+1){1'b0}};
    else begin
      case ({din_hs_s, pop_s})
        2'b10:   fifo_count_r <= fifo_count_r + (ADDR_WIDTH+1)'(1'b1);
        2'b01:   fifo_count_r <= fifo_count_r - (ADDR_WIDTH+1)'(1'b1);
        default: fifo_count_r <= fifo_count_r;
      endcase
    end
  end

  // Lane memories; contents need no reset since every tile rewrites them
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        mem_r[i][wr_ptr_r[ADDR_WIDTH-1:0]] <= io.unshift_din[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Output register: load on pop, hold under backpressure, drop valid after take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_r      <= {(WIDTH*DATA_WIDTH){1'b0}};
      dout_vld_r  <= 1'b0;
      dout_last_r <= 1'b0;
    end else if (Rst) begin
      dout_r      <= {(WIDTH*DATA_WIDTH){1'b0}};
      dout_vld_r  <= 1'b0;
      dout_last_r <= 1'b0;
    end else if (pop_s) begin
      for (int i = 0; i < WIDTH; i++) begin
        dout_r[i*DATA_WIDTH +: DATA_WIDTH] <= mem_r[i][rd_addr_s[i]];
      end
      dout_vld_r  <= 1'b1;
      dout_last_r <= (rd_ptr_r == (n_r - (ADDR_WIDTH+1)'(1'b1)));
    end else if (dout_hs_s) begin
      dout_vld_r  <= 1'b0;
      dout_last_r <= 1'b0;
    end
  end

  assign io.unshift_dout      = dout_r;
  assign io.unshift_dout_vld  = dout_vld_r;
  assign io.unshift_dout_last = dout_last_r;
  assign fifo_count           = fifo_count_r;

endmodule
